// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 for the multicycle CPU: Status/Cause/EPC/Count/Compare registers,
// exception entry, ERET return, masked external interrupts and the Count/Compare timer.
module cp0_irq_ctrl #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       N_IRQ      = 6,
  parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(32'h0000_0004),
  parameter bit                SYNC_IRQ   = 1'b1,
  parameter bit                TIMER_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mfc0,
  input  logic              mtc0,
  input  logic              eret,
  input  logic              exception,
  input  logic [4:0]        cause_code,
  input  logic              int_ok,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] wdata,
  input  logic [N_IRQ-1:0]  irq,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] status,
  output logic [DATA_W-1:0] exc_addr,
  output logic              redirect,
  output logic              timer_irq
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic [DATA_W-1:0] r_status;
  logic [DATA_W-1:0] r_epc;
  logic [DATA_W-1:0] r_exc_addr;
  logic [4:0]        r_exc_code;
  logic              r_ip15;
  logic              r_redirect;

  logic [N_IRQ-1:0]  w_irq;
  logic [7:0]        w_ip;
  logic [7:0]        w_im;
  logic              w_ie;
  logic              w_exl;
  logic              w_int_pend;
  logic              w_do_exc;
  logic              w_do_int;
  logic              w_do_eret;
  logic              w_do_mtc0;
  logic [DATA_W-1:0] w_cause;
  logic [DATA_W-1:0] w_rdata;

  // Optional two-flop synchroniser on the asynchronous interrupt lines
  generate
    if (SYNC_IRQ) begin : g_sync
      logic [N_IRQ-1:0] r_irq_s1;
      logic [N_IRQ-1:0] r_irq_s2;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_irq_s1 <= '0;
          r_irq_s2 <= '0;
        end else begin
          r_irq_s1 <= irq;
          r_irq_s2 <= r_irq_s1;
        end
      end
      assign w_irq = r_irq_s2;
    end else begin : g_nosync
      assign w_irq = irq;
    end
  endgenerate

  always_comb begin
    w_ip            = '0;
    w_ip[N_IRQ-1:0] = w_irq;
    w_ip[7]         = r_ip15;
    w_cause         = '0;
    w_cause[15:8]   = w_ip;
    w_cause[6:2]    = r_exc_code;
  end

  assign w_im       = r_status[15:8];
  assign w_ie       = r_status[0];
  assign w_exl      = r_status[1];
  assign w_int_pend = w_ie & ~w_exl & (|(w_ip & w_im)) & int_ok;

  // One winner per cycle: exception > interrupt > eret > mtc0
  assign w_do_exc  = exception;
  assign w_do_int  = ~exception & w_int_pend;
  assign w_do_eret = ~exception & ~w_int_pend & eret;
  assign w_do_mtc0 = ~exception & ~w_int_pend & ~eret & mtc0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_compare  <= '0;
      r_status   <= '0;
      r_epc      <= '0;
      r_exc_addr <= '0;
      r_exc_code <= '0;
      r_ip15     <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;

      if (!TIMER_EN)
        r_count <= '0;
      else if (w_do_mtc0 && rd == REG_COUNT)
        r_count <= wdata;
      else
        r_count <= r_count + DATA_W'(1);

      // Writing Compare acknowledges the timer interrupt, even on a match cycle
      if (!TIMER_EN)
        r_ip15 <= 1'b0;
      else if (w_do_mtc0 && rd == REG_COMPARE)
        r_ip15 <= 1'b0;
      else if (r_count == r_compare)
        r_ip15 <= 1'b1;

      if (w_do_exc || w_do_int) begin
        r_status[1] <= 1'b1;
        r_exc_code  <= w_do_exc ? cause_code : 5'd0;
        if (!w_exl)
          r_epc <= pc;
        r_exc_addr  <= EXC_VECTOR;
        r_redirect  <= 1'b1;
      end else if (w_do_eret) begin
        r_status[1] <= 1'b0;
        r_exc_addr  <= r_epc;
        r_redirect  <= 1'b1;
      end else if (w_do_mtc0) begin
        case (rd)
          REG_COMPARE: r_compare  <= wdata;
          REG_STATUS:  r_status   <= wdata;
          REG_CAUSE:   r_exc_code <= wdata[6:2];
          REG_EPC:     r_epc      <= wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (mfc0) begin
      case (rd)
        REG_COUNT:   w_rdata = r_count;
        REG_COMPARE: w_rdata = r_compare;
        REG_STATUS:  w_rdata = r_status;
        REG_CAUSE:   w_rdata = w_cause;
        REG_EPC:     w_rdata = r_epc;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign rdata     = w_rdata;
  assign status    = r_status;
  assign exc_addr  = r_exc_addr;
  assign redirect  = r_redirect;
  assign timer_irq = r_ip15;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: vector table for single-cycle actions plus
// hand-written timer, interrupt, mask and reset sequences.
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mfc0, mtc0, eret, exception, int_ok;
  logic [4:0]  cause_code, rd;
  logic [31:0] pc, wdata;
  logic [5:0]  irq;
  logic [31:0] rdata, status, exc_addr;
  logic        redirect, timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_irq_ctrl dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
    .exception(exception), .cause_code(cause_code), .int_ok(int_ok), .rd(rd),
    .pc(pc), .wdata(wdata), .irq(irq), .rdata(rdata), .status(status),
    .exc_addr(exc_addr), .redirect(redirect), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mfc0, mtc0, eret, exc;
    logic [4:0]  cc, rd;
    logic [31:0] pc, wdata;
    logic [31:0] e_rdata;
    logic        e_redir;
    logic [31:0] e_addr, e_status;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t v(logic a_mfc0, logic a_mtc0, logic a_eret, logic a_exc,
                             logic [4:0] a_cc, logic [4:0] a_rd, logic [31:0] a_pc,
                             logic [31:0] a_wdata, logic [31:0] a_rdata, logic a_redir,
                             logic [31:0] a_addr, logic [31:0] a_status);
    vec_t t;
    t.mfc0 = a_mfc0; t.mtc0 = a_mtc0; t.eret = a_eret; t.exc = a_exc;
    t.cc = a_cc; t.rd = a_rd; t.pc = a_pc; t.wdata = a_wdata;
    t.e_rdata = a_rdata; t.e_redir = a_redir; t.e_addr = a_addr; t.e_status = a_status;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    mfc0 = 0; mtc0 = 0; eret = 0; exception = 0; int_ok = 0;
    cause_code = 0; rd = 0; pc = 0; wdata = 0; irq = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = v(0,0,0,1, 8, 0,32'h40, 0,          0,      1, 32'h4,   32'h2);
    vecs[1]  = v(1,0,0,0, 0,14,0,      0,          32'h40, 0, 32'h4,   32'h2);
    vecs[2]  = v(1,0,0,0, 0,13,0,      0,          32'h20, 0, 32'h4,   32'h2);
    vecs[3]  = v(1,0,0,1, 9,12,32'h80, 0,          32'h2,  1, 32'h4,   32'h2);
    vecs[4]  = v(1,0,0,0, 0,14,0,      0,          32'h40, 0, 32'h4,   32'h2);
    vecs[5]  = v(1,0,0,0, 0,13,0,      0,          32'h24, 0, 32'h4,   32'h2);
    vecs[6]  = v(1,0,1,0, 0,14,0,      0,          32'h40, 1, 32'h40,  32'h0);
    vecs[7]  = v(0,0,1,0, 0, 0,0,      0,          0,      1, 32'h40,  32'h0);
    vecs[8]  = v(0,0,0,0, 0, 0,0,      0,          0,      0, 32'h40,  32'h0);
    vecs[9]  = v(0,1,0,0, 0,13,0,      32'hFFFFFFFF,0,     0, 32'h40,  32'h0);
    vecs[10] = v(1,0,0,0, 0,13,0,      0,          32'h7C, 0, 32'h40,  32'h0);
    vecs[11] = v(0,1,0,0, 0,20,0,      32'h1234,   0,      0, 32'h40,  32'h0);
    vecs[12] = v(1,0,0,0, 0,20,0,      0,          0,      0, 32'h40,  32'h0);
    vecs[13] = v(0,0,1,1, 4, 0,32'h100,0,          0,      1, 32'h4,   32'h2);
    vecs[14] = v(1,0,0,0, 0,14,0,      0,          32'h100,0, 32'h4,   32'h2);
    vecs[15] = v(0,1,0,1,10,12,32'h200,32'hFFFF,   0,      1, 32'h4,   32'h2);
    vecs[16] = v(1,0,0,0, 0,14,0,      0,          32'h100,0, 32'h4,   32'h2);
    vecs[17] = v(0,0,1,0, 0, 0,0,      0,          0,      1, 32'h100, 32'h0);
    vecs[18] = v(0,1,0,0, 0,12,0,      32'h401,    0,      0, 32'h100, 32'h401);
    vecs[19] = v(0,1,0,0, 0,14,0,      32'h3000,   0,      0, 32'h100, 32'h401);
    vecs[20] = v(1,0,0,0, 0,14,0,      0,          32'h3000,0,32'h100, 32'h401);

    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_redirect", 32'(redirect), 32'h0);
    rst = 1'b1;

    // Cycle 0 after reset: Count reads 0
    mfc0 = 1;
    foreach (vecs[i]) ;
    rd = 5'd12; #1; chk("reset_status_rd", rdata, 32'h0);
    rd = 5'd13; #1; chk("reset_cause_rd", rdata, 32'h0);
    rd = 5'd14; #1; chk("reset_epc_rd", rdata, 32'h0);
    rd = 5'd9;  #1; chk("reset_count_rd", rdata, 32'h0);
    chk("reset_exc_addr", exc_addr, 32'h0);
    chk("reset_status", status, 32'h0);
    chk("reset_timer_irq", 32'(timer_irq), 32'h0);
    mfc0 = 0; mtc0 = 1; rd = 5'd11; wdata = 32'd5;
    step();

    // Count runs 1,2,...; Count==Compare at cycle 5, IP[15] visible from cycle 6
    clear_in();
    for (int c = 1; c <= 6; c++) begin
      mfc0 = 1; rd = 5'd9; #1;
      chk($sformatf("count_c%0d", c), rdata, 32'(c));
      chk($sformatf("timer_irq_c%0d", c), 32'(timer_irq), (c >= 6) ? 32'h1 : 32'h0);
      if (c == 2) begin
        rd = 5'd11; #1; chk("compare_rd", rdata, 32'h5);
      end
      if (c == 6) begin
        rd = 5'd13; #1; chk("cause_ip15", rdata, 32'h8000);
        mfc0 = 0; mtc0 = 1; rd = 5'd11; wdata = 32'hFFFF_FFF0;
      end
      step();
    end
    clear_in();
    mfc0 = 1; rd = 5'd13; #1;
    chk("timer_cleared", 32'(timer_irq), 32'h0);
    chk("cause_ip15_cleared", rdata, 32'h0);

    for (int i = 0; i < 21; i++) begin
      clear_in();
      mfc0 = vecs[i].mfc0; mtc0 = vecs[i].mtc0; eret = vecs[i].eret;
      exception = vecs[i].exc; cause_code = vecs[i].cc; rd = vecs[i].rd;
      pc = vecs[i].pc; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      step();
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      chk($sformatf("v%0d_exc_addr", i), exc_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_status", i), status, vecs[i].e_status);
    end

    // Unmasked irq[2]: two sync cycles, then interrupt taken
    clear_in();
    irq = 6'b000100; int_ok = 1; pc = 32'h500;
    step(); chk("irq_lat1", 32'(redirect), 32'h0);
    step(); chk("irq_lat2", 32'(redirect), 32'h0);
    mfc0 = 1; rd = 5'd13; #1;
    chk("irq_cause_pre", rdata, 32'h428);
    step();
    chk("irq_redirect", 32'(redirect), 32'h1);
    chk("irq_exc_addr", exc_addr, 32'h4);
    chk("irq_status", status, 32'h403);
    clear_in();
    mfc0 = 1; rd = 5'd13; #1; chk("irq_cause_post", rdata, 32'h400);
    rd = 5'd14; #1; chk("irq_epc", rdata, 32'h500);
    step(); chk("irq_pulse_end", 32'(redirect), 32'h0);
    step(); step();
    mfc0 = 1; rd = 5'd13; #1; chk("irq_ip_dropped", rdata, 32'h0);
    clear_in(); eret = 1;
    step();
    chk("irq_eret_redirect", 32'(redirect), 32'h1);
    chk("irq_eret_addr", exc_addr, 32'h500);
    chk("irq_eret_status", status, 32'h401);

    // IM[10] cleared: pending irq must not be taken
    clear_in(); mtc0 = 1; rd = 5'd12; wdata = 32'h1;
    step(); chk("mask_status", status, 32'h1);
    clear_in(); irq = 6'b000100; int_ok = 1;
    for (int k = 0; k < 4; k++) begin
      step(); chk($sformatf("masked_c%0d", k), 32'(redirect), 32'h0);
    end
    mfc0 = 1; rd = 5'd13; #1; chk("masked_cause", rdata, 32'h400);
    clear_in();
    repeat (3) step();

    // Reset asserted mid-pulse kills the redirect immediately
    exception = 1; cause_code = 5'd8; pc = 32'h40;
    step(); chk("rst_pre_redirect", 32'(redirect), 32'h1);
    clear_in();
    rst = 1'b0; #1;
    chk("rst_mid_redirect", 32'(redirect), 32'h0);
    chk("rst_mid_exc_addr", exc_addr, 32'h0);
    chk("rst_mid_status", status, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("rst_post_redirect", 32'(redirect), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
